// File: rtl/riscv_mem_pkg.sv
// Shared data-memory definitions for the RV32I core and its boot loader:
// word width, store-size encodings and loader state encoding.
package riscv_mem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } ld_state_e;

endpackage

// File: rtl/pl_loader_fifo.sv
// First-word-fall-through FIFO for loader beats; head entry is visible
// on o_rdata whenever o_empty is low.
module pl_loader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Extra pointer MSB distinguishes full from empty.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/pl_mem_loader.sv
// Boot loader between riscv_cpu and data_mem: streams an image into memory
// while the CPU is held in reset. Checksum enabled by PL_MEM_LOADER_CSUM_EN.
module pl_mem_loader
  import riscv_mem_pkg::*;
#(
  parameter int          XLEN       = riscv_mem_pkg::XLEN,
  parameter int          ADDR_W     = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ext_valid,
  output logic              o_ext_ready,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [XLEN-1:0]   i_ext_wdata,
  input  logic [2:0]        i_ext_funct3,
  input  logic              i_ext_auto_inc,
  input  logic              i_ext_last,
  input  logic              i_cpu_memwrite,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [XLEN-1:0]   i_cpu_wdata,
  input  logic [2:0]        i_cpu_funct3,
  input  logic              i_mem_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [2:0]        o_mem_funct3,
  output logic              o_cpu_reset,
  output logic              o_busy,
  output logic [15:0]       o_load_count,
  output logic [XLEN-1:0]   o_load_csum
);

  localparam int FW = ADDR_W + XLEN + 3;

  ld_state_e         r_state;
  ld_state_e         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_count;
  logic              r_cpu_reset;
  logic              r_busy;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] w_beat_addr;
  logic [FW-1:0]     w_fifo_in;
  logic [FW-1:0]     w_fifo_out;
  logic [ADDR_W-1:0] w_head_addr;
  logic [XLEN-1:0]   w_head_wdata;
  logic [2:0]        w_head_funct3;

  assign w_beat_addr = i_ext_auto_inc ? r_addr : i_ext_addr;
  assign w_fifo_in   = {w_beat_addr, i_ext_wdata, i_ext_funct3};
  assign {w_head_addr, w_head_wdata, w_head_funct3} = w_fifo_out;

  assign w_push = i_ext_valid && o_ext_ready;

  pl_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_wdata (w_fifo_in),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= LOAD;
      r_addr      <= BASE_ADDR;
      r_count     <= '0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_cpu_reset <= (r_state != RUN);
      r_busy      <= (r_state != RUN);
      if (w_push) r_addr <= w_beat_addr + ADDR_W'(4);
      if (w_pop && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
    end
  end

  always_comb begin
    w_next       = r_state;
    o_ext_ready  = 1'b0;
    w_pop        = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = w_head_addr;
    o_mem_wdata  = w_head_wdata;
    o_mem_funct3 = w_head_funct3;
    unique case (r_state)
      LOAD: begin
        o_ext_ready = !w_full && !i_reset;
        o_mem_we    = !w_empty && !i_reset;
        w_pop       = o_mem_we && i_mem_ready;
        if (w_push && i_ext_last) w_next = DRAIN;
      end
      DRAIN: begin
        o_mem_we = !w_empty && !i_reset;
        w_pop    = o_mem_we && i_mem_ready;
        if (w_empty) w_next = RUN;
      end
      RUN: begin
        o_mem_we     = i_cpu_memwrite;
        o_mem_addr   = i_cpu_addr;
        o_mem_wdata  = i_cpu_wdata;
        o_mem_funct3 = i_cpu_funct3;
      end
      default: w_next = LOAD;
    endcase
  end

`ifdef PL_MEM_LOADER_CSUM_EN
  logic [XLEN-1:0] r_csum;

  // Pops never happen in RUN, so the sum freezes there on its own.
  always_ff @(posedge i_clk) begin
    if (i_reset)    r_csum <= '0;
    else if (w_pop) r_csum <= r_csum + w_head_wdata;
  end

  assign o_load_csum = r_csum;
`else
  assign o_load_csum = '0;
`endif

  assign o_cpu_reset  = r_cpu_reset;
  assign o_busy       = r_busy;
  assign o_load_count = r_count;

endmodule
